// File: rtl/frog_hazard.sv
// Frog collision and life manager: scans N_OBJ car/log objects once per frame,
// then resolves car, drown and log-riding outcomes and runs the death/respawn sequence.
module frog_hazard #(
   parameter int N_OBJ        = 8,
   parameter int FROG_SIZE    = 32,
   parameter int CAR_SIZE     = 40,
   parameter int LOG_SIZE     = 80,
   parameter int LANE_H       = 32,
   parameter int ROAD_Y_MIN   = 256,
   parameter int ROAD_Y_MAX   = 415,
   parameter int RIVER_Y_MIN  = 64,
   parameter int RIVER_Y_MAX  = 223,
   parameter int DEATH_FRAMES = 60
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic       Start,
   input  logic [9:0] FrogX,
   input  logic [9:0] FrogY,
   input  logic [9:0] ObjX,
   input  logic [9:0] ObjY,
   input  logic       ObjIsLog,
   input  logic       ObjRight,
   output logic [2:0] ObjSel,
   output logic       ScanDone,
   output logic       Hit,
   output logic       OnLog,
   output logic       LogDir,
   output logic       Dying,
   output logic [1:0] Lives,
   output logic       RespawnReq,
   output logic       GameOver
);

   localparam int TW = $clog2(DEATH_FRAMES + 1);
   localparam logic [10:0] FROG_M1  = 11'(FROG_SIZE - 1);
   localparam logic [10:0] LANE_M1  = 11'(LANE_H - 1);
   localparam logic [10:0] CAR_W    = 11'(CAR_SIZE);
   localparam logic [10:0] LOG_W    = 11'(LOG_SIZE);
   localparam logic [10:0] ROAD_LO  = 11'(ROAD_Y_MIN);
   localparam logic [10:0] ROAD_HI  = 11'(ROAD_Y_MAX);
   localparam logic [10:0] RIVER_LO = 11'(RIVER_Y_MIN);
   localparam logic [10:0] RIVER_HI = 11'(RIVER_Y_MAX);
   localparam logic [2:0]  LAST_SEL = 3'(N_OBJ - 1);

   typedef enum logic [1:0] {SCAN_IDLE, SCAN_RUN, SCAN_RESOLVE} scan_t;
   typedef enum logic [1:0] {ALIVE, DYING, OVER} life_t;

   scan_t scan_q, scan_d;
   life_t life_q, life_d;

   logic [10:0]   frog_x, frog_y;
   logic          car_seen, log_seen, log_dir;
   logic [TW-1:0] timer;

   logic [10:0] obj_x, obj_y, obj_w, x_lo, x_hi;
   logic        overlap, start_ok, resolve, in_road, in_river, hazard;
   logic        hit_d, respawn_d;

   // All extents are widened to 11 bits so FrogX+31 and ObjY+31 never wrap.
   assign obj_x   = {1'b0, ObjX};
   assign obj_y   = {1'b0, ObjY};
   assign obj_w   = ObjIsLog ? LOG_W : CAR_W;
   assign x_lo    = (obj_x >= obj_w) ? (obj_x - obj_w) : 11'd0;
   assign x_hi    = obj_x - 11'd1;
   assign overlap = (obj_x != 11'd0) &&
                    (frog_x <= x_hi) && (x_lo <= frog_x + FROG_M1) &&
                    (frog_y <= obj_y + LANE_M1) && (obj_y <= frog_y + FROG_M1);

   assign start_ok = (scan_q == SCAN_IDLE) && Start;
   assign resolve  = (scan_q == SCAN_RESOLVE);
   assign in_road  = (frog_y >= ROAD_LO) && (frog_y <= ROAD_HI);
   assign in_river = (frog_y >= RIVER_LO) && (frog_y <= RIVER_HI);
   assign hazard   = (in_road && car_seen) || (in_river && !log_seen);

   assign Dying    = (life_q == DYING);
   assign GameOver = (life_q == OVER);

   always_ff @(posedge frame_clk) begin
      if (!Reset) begin
         scan_q <= SCAN_IDLE;
         life_q <= ALIVE;
      end else begin
         scan_q <= scan_d;
         life_q <= life_d;
      end
   end

   always_comb begin
      scan_d = scan_q;
      case (scan_q)
         SCAN_IDLE:    if (Start) scan_d = SCAN_RUN;
         SCAN_RUN:     if (ObjSel == LAST_SEL) scan_d = SCAN_RESOLVE;
         SCAN_RESOLVE: scan_d = SCAN_IDLE;
         default:      scan_d = SCAN_IDLE;
      endcase
   end

   always_comb begin
      life_d    = life_q;
      hit_d     = 1'b0;
      respawn_d = 1'b0;
      case (life_q)
         ALIVE: if (resolve && hazard) begin
            hit_d  = 1'b1;
            life_d = DYING;
         end
         DYING: if (start_ok && timer == '0) begin
            if (Lives == 2'd0) begin
               life_d = OVER;
            end else begin
               respawn_d = 1'b1;
               life_d    = ALIVE;
            end
         end
         OVER:    life_d = OVER;
         default: life_d = ALIVE;
      endcase
   end

   // Per-frame scan data: latched frog position and running overlap summary.
   always_ff @(posedge frame_clk) begin
      if (start_ok) begin
         frog_x   <= {1'b0, FrogX};
         frog_y   <= {1'b0, FrogY};
         car_seen <= 1'b0;
         log_seen <= 1'b0;
         log_dir  <= 1'b0;
      end else if (scan_q == SCAN_RUN && overlap) begin
         if (!ObjIsLog) begin
            car_seen <= 1'b1;
         end else if (!log_seen) begin
            log_seen <= 1'b1;
            log_dir  <= ObjRight;
         end
      end
   end

   always_ff @(posedge frame_clk) begin
      if (!Reset) begin
         ObjSel     <= 3'd0;
         ScanDone   <= 1'b0;
         Hit        <= 1'b0;
         RespawnReq <= 1'b0;
         OnLog      <= 1'b0;
         LogDir     <= 1'b0;
         Lives      <= 2'd3;
         timer      <= '0;
      end else begin
         ScanDone   <= resolve;
         Hit        <= hit_d;
         RespawnReq <= respawn_d;
         if (start_ok || (scan_q == SCAN_RUN && ObjSel == LAST_SEL)) begin
            ObjSel <= 3'd0;
         end else if (scan_q == SCAN_RUN) begin
            ObjSel <= ObjSel + 3'd1;
         end
         if (resolve) begin
            if (life_q == ALIVE && in_river && log_seen) begin
               OnLog  <= 1'b1;
               LogDir <= log_dir;
            end else begin
               OnLog <= 1'b0;
            end
         end
         if (hit_d) begin
            timer <= TW'(DEATH_FRAMES);
            if (Lives != 2'd0) Lives <= Lives - 2'd1;
         end else if (life_q == DYING && start_ok && timer != '0) begin
            timer <= timer - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_frog_hazard.sv
// Randomized and directed bench for frog_hazard against a frame-level reference model
// of overlap, zone, death timer and lives.
module tb_frog_hazard;

   logic       frame_clk = 1'b0;
   logic       Reset = 1'b0;
   logic       Start = 1'b0;
   logic [9:0] FrogX = '0, FrogY = '0;
   logic [9:0] ObjX, ObjY;
   logic       ObjIsLog, ObjRight;
   logic [2:0] ObjSel;
   logic       ScanDone, Hit, OnLog, LogDir, Dying, RespawnReq, GameOver;
   logic [1:0] Lives;

   logic [9:0] obj_x [8];
   logic [9:0] obj_y [8];
   logic       obj_log [8];
   logic       obj_right [8];

   assign ObjX     = obj_x[ObjSel];
   assign ObjY     = obj_y[ObjSel];
   assign ObjIsLog = obj_log[ObjSel];
   assign ObjRight = obj_right[ObjSel];

   frog_hazard dut (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .Start     (Start),
      .FrogX     (FrogX),
      .FrogY     (FrogY),
      .ObjX      (ObjX),
      .ObjY      (ObjY),
      .ObjIsLog  (ObjIsLog),
      .ObjRight  (ObjRight),
      .ObjSel    (ObjSel),
      .ScanDone  (ScanDone),
      .Hit       (Hit),
      .OnLog     (OnLog),
      .LogDir    (LogDir),
      .Dying     (Dying),
      .Lives     (Lives),
      .RespawnReq(RespawnReq),
      .GameOver  (GameOver)
   );

   always #5 frame_clk = ~frame_clk;

   int n_cmp = 0;
   int n_bad = 0;

   // reference game state: 0 alive, 1 dying, 2 over
   int m_state, m_lives, m_timer;
   int m_onlog, m_dir;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_lives = 3;
      m_timer = 0;
      m_onlog = 0;
      m_dir   = 0;
   endtask

   task automatic clear_objs();
      for (int i = 0; i < 8; i++) begin
         obj_x[i] = '0; obj_y[i] = '0; obj_log[i] = 1'b0; obj_right[i] = 1'b0;
      end
   endtask

   task automatic apply_reset();
      @(negedge frame_clk);
      Reset = 1'b0;
      @(negedge frame_clk);
      Reset = 1'b1;
      model_reset();
   endtask

   function automatic int clamp10(input int v);
      if (v < 0) return 0;
      if (v > 1023) return 1023;
      return v;
   endfunction

   task automatic do_scan(input bit extra_start);
      int  exp_resp, early, fx, fy, car_ov, log_ov, ldir, w, lo, hi, hazard, exp_hit;
      bit  road, river, x_ok, y_ok;
      exp_resp = 0;
      if (m_state == 1) begin
         if (m_timer == 0) begin
            if (m_lives == 0) m_state = 2;
            else begin m_state = 0; exp_resp = 1; end
         end else begin
            m_timer--;
         end
      end
      @(negedge frame_clk);
      Start = 1'b1;
      @(negedge frame_clk);
      Start = 1'b0;
      check("respawn", RespawnReq, exp_resp);
      early = 0;
      for (int i = 0; i < 8; i++) begin
         Start = extra_start && (i == 2);
         @(negedge frame_clk);
         if (ScanDone || Hit || RespawnReq) early = 1;
      end
      Start = 1'b0;
      fx = int'(FrogX); fy = int'(FrogY);
      car_ov = 0; log_ov = 0; ldir = 0;
      for (int i = 0; i < 8; i++) begin
         w  = obj_log[i] ? 80 : 40;
         hi = int'(obj_x[i]) - 1;
         lo = (int'(obj_x[i]) >= w) ? int'(obj_x[i]) - w : 0;
         x_ok = (obj_x[i] != 0) && (fx <= hi) && (lo <= fx + 31);
         y_ok = (fy <= int'(obj_y[i]) + 31) && (int'(obj_y[i]) <= fy + 31);
         if (x_ok && y_ok) begin
            if (!obj_log[i]) car_ov = 1;
            else if (!log_ov) begin log_ov = 1; ldir = int'(obj_right[i]); end
         end
      end
      road   = (fy >= 256) && (fy <= 415);
      river  = (fy >= 64) && (fy <= 223);
      hazard = (road && car_ov) || (river && !log_ov);
      exp_hit = 0;
      if (m_state == 0 && river && log_ov) begin m_onlog = 1; m_dir = ldir; end
      else m_onlog = 0;
      if (m_state == 0 && hazard) begin
         exp_hit = 1;
         if (m_lives > 0) m_lives--;
         m_timer = 60;
         m_state = 1;
      end
      @(negedge frame_clk);
      check("early_pulse", early, 0);
      check("scan_done", ScanDone, 1);
      check("hit", Hit, exp_hit);
      check("on_log", OnLog, m_onlog);
      check("log_dir", LogDir, m_dir);
      check("dying", Dying, m_state == 1);
      check("lives", Lives, m_lives);
      check("game_over", GameOver, m_state == 2);
   endtask

   task automatic car_setup(input int fx);
      clear_objs();
      obj_x[3] = 10'd120; obj_y[3] = 10'd300;
      FrogX = 10'(fx); FrogY = 10'd300;
   endtask

   task automatic ride_out_death();
      FrogY = 10'd20;
      for (int i = 0; i < 61; i++) do_scan(1'b0);
   endtask

   initial begin
      clear_objs();
      model_reset();
      repeat (2) @(negedge frame_clk);
      Reset = 1'b1;
      check("rst_objsel", ObjSel, 0);
      check("rst_lives", Lives, 3);
      check("rst_done", ScanDone, 0);
      check("rst_hit", Hit, 0);
      check("rst_onlog", OnLog, 0);
      check("rst_logdir", LogDir, 0);
      check("rst_dying", Dying, 0);
      check("rst_resp", RespawnReq, 0);
      check("rst_over", GameOver, 0);

      // car strike, then edge-touch vs one-pixel overlap
      car_setup(90);
      do_scan(1'b0);
      check("car_lives", Lives, 2);
      check("car_dying", Dying, 1);
      apply_reset();
      car_setup(120);
      do_scan(1'b0);
      check("edge_nohit", Lives, 3);
      car_setup(119);
      do_scan(1'b1);
      check("px_hit_lives", Lives, 2);

      // log riding then drowning just past the log's right edge
      apply_reset();
      clear_objs();
      obj_x[5] = 10'd200; obj_y[5] = 10'd100; obj_log[5] = 1'b1; obj_right[5] = 1'b1;
      FrogX = 10'd130; FrogY = 10'd100;
      do_scan(1'b0);
      check("ride_onlog", OnLog, 1);
      check("ride_dir", LogDir, 1);
      FrogX = 10'd200;
      do_scan(1'b0);
      check("drown_lives", Lives, 2);

      // three deaths to game over, then hazards are ignored
      apply_reset();
      for (int d = 0; d < 3; d++) begin
         car_setup(90);
         do_scan(1'b0);
         ride_out_death();
      end
      check("over_flag", GameOver, 1);
      check("over_lives", Lives, 0);
      check("over_dying", Dying, 0);
      car_setup(90);
      do_scan(1'b0);

      // reset in the middle of a scan with a hazard pending
      apply_reset();
      car_setup(90);
      @(negedge frame_clk);
      Start = 1'b1;
      @(negedge frame_clk);
      Start = 1'b0;
      repeat (4) @(negedge frame_clk);
      check("mid_sel", ObjSel, 4);
      Reset = 1'b0;
      @(negedge frame_clk);
      Reset = 1'b1;
      model_reset();
      check("mid_rst_sel", ObjSel, 0);
      check("mid_rst_lives", Lives, 3);
      for (int i = 0; i < 8; i++) begin
         check("mid_rst_quiet", {ScanDone, Hit, RespawnReq}, 0);
         @(negedge frame_clk);
      end
      do_scan(1'b0);

      // randomized frames
      for (int r = 0; r < 3; r++) begin
         apply_reset();
         for (int s = 0; s < 150; s++) begin
            FrogX = 10'($urandom_range(0, 600));
            FrogY = 10'($urandom_range(0, 480));
            for (int i = 0; i < 8; i++) begin
               obj_log[i]   = 1'($urandom_range(0, 1));
               obj_right[i] = 1'($urandom_range(0, 1));
               obj_x[i] = ($urandom_range(0, 7) == 0) ? 10'd0
                          : 10'(clamp10(int'(FrogX) + int'($urandom_range(0, 140)) - 20));
               obj_y[i] = 10'(clamp10(int'(FrogY) + int'($urandom_range(0, 80)) - 40));
            end
            do_scan(1'($urandom_range(0, 1)));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/frog_hazard.md
FROG_HAZARD -- requirements
Module: frog_hazard

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- N_OBJ, 8, number of car/log objects scanned per frame
- FROG_SIZE, 32, frog width and height in pixels
- CAR_SIZE, 40, car width; LOG_SIZE, 80, log width
- LANE_H, 32, object height in pixels
- ROAD_Y_MIN, 256, ROAD_Y_MAX, 415, road zone rows inclusive
- RIVER_Y_MIN, 64, RIVER_Y_MAX, 223, river zone rows inclusive
- DEATH_FRAMES, 60, frames spent in death animation
REQ-002 Ports, one per line: name, direction, width, meaning (clock and reset first).
- frame_clk, in, 1, sole clock; all state updates on its rising edge
- Reset, in, 1, synchronous active-low reset
- Start, in, 1, one-cycle pulse per frame that begins a scan
- FrogX, FrogY, in, 10 each, frog top-left pixel
- ObjX, ObjY, in, 10 each, position of the object addressed by ObjSel (same-cycle combinational return from carlog bank)
- ObjIsLog, ObjRight, in, 1 each, type and direction of the addressed object
- ObjSel, out, 3, object index being sampled
- ScanDone, out, 1, one-cycle pulse when results update
- Hit, out, 1, one-cycle pulse on a new death
- OnLog, out, 1, frog riding a log (level, held between scans)
- LogDir, out, 1, ObjRight of the ridden log
- Dying, out, 1, death animation active
- Lives, out, 2, remaining lives
- RespawnReq, out, 1, one-cycle pulse requesting frog return to start
- GameOver, out, 1, sticky end-of-game flag

Function
REQ-003 Scan FSM states SCAN_IDLE, SCAN_RUN, SCAN_RESOLVE.
REQ-004 SCAN_IDLE + Start=1: latch FrogX/FrogY, ObjSel<=0, go SCAN_RUN; Start in any other state ignored.
REQ-005 SCAN_RUN: each cycle sample inputs for current ObjSel; after ObjSel==N_OBJ-1 sampled, go SCAN_RESOLVE; else ObjSel increments.
REQ-006 SCAN_RESOLVE: one cycle; update OnLog/LogDir, evaluate hazard, pulse ScanDone, return to SCAN_IDLE; Start-to-ScanDone latency = N_OBJ+1 cycles.
REQ-007 Object horizontal extent [ObjX-W, ObjX-1], W = LOG_SIZE if ObjIsLog else CAR_SIZE; if ObjX<W, extent [0, ObjX-1]; ObjX=0 means no extent.
REQ-008 Object vertical extent [ObjY, ObjY+LANE_H-1]; frog extent [FrogX, FrogX+FROG_SIZE-1] x [FrogY, FrogY+FROG_SIZE-1].
REQ-009 Overlap requires intersection of at least one pixel on both axes; all sums computed at 11 bits, no wrap.
REQ-010 Frog zone from latched FrogY: road if ROAD_Y_MIN<=FrogY<=ROAD_Y_MAX, river if RIVER_Y_MIN<=FrogY<=RIVER_Y_MAX, else safe.
REQ-011 Car hazard: road zone and any non-log object overlaps; drown hazard: river zone and no log overlaps; car hazard takes priority; both are one death.
REQ-012 OnLog=1 only in river zone with a log overlap while life state ALIVE; LogDir = ObjRight of lowest-index overlapping log; otherwise OnLog=0, LogDir holds.
REQ-013 Life FSM states ALIVE, DYING, OVER.
REQ-014 ALIVE + hazard at SCAN_RESOLVE: Hit pulses same cycle, Lives decrements, timer<=DEATH_FRAMES, go DYING.
REQ-015 DYING: Dying=1; timer decrements on each Start; hazards ignored; scans continue.
REQ-016 DYING with timer 0 at a Start: if Lives==0 go OVER, else pulse RespawnReq and go ALIVE.
REQ-017 OVER: GameOver=1, Dying=0, OnLog=0; sticky until Reset; scans continue, Hit never pulses.
REQ-018 Lives never decrements below 0; Hit with Lives=1 yields Lives=0 and later OVER.

Reset
REQ-019 Reset=0 at a rising edge: scan SCAN_IDLE, life ALIVE, ObjSel=0, Lives=3, timer=0, all other outputs 0.
REQ-020 Reset mid-scan or mid-death aborts immediately; no ScanDone, Hit or RespawnReq pulse that cycle or the next.
REQ-021 Reset has priority over Start and all hazard events.

Verification
REQ-022 FrogY=300, car 3 at ObjX=120/ObjY=300, FrogX=90, Start -> ScanDone and Hit at cycle 9, Lives 3->2, Dying=1.
REQ-023 FrogY=100, log 5 at ObjX=200/ObjY=100, ObjRight=1, FrogX=130 -> OnLog=1, LogDir=1, no Hit; FrogX=200 -> Hit (drown).
REQ-024 Car ObjX=120, FrogX=120 (edge touch, no pixel overlap) -> no Hit; FrogX=119 -> Hit.
REQ-025 Hit then 61 Start pulses -> RespawnReq single pulse on the 61st, Dying=0; three deaths -> GameOver=1, Lives=0, further hazards no Hit.
REQ-026 Reset=0 during SCAN_RUN at ObjSel=4 with hazard present -> ObjSel=0, Lives=3, no Hit/ScanDone; Start during SCAN_RUN -> ignored, latency unchanged.
